// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache between IF and instruction memory.
// Hits return the word combinationally; misses stall IF while one 256-bit block is fetched.
module icache_direct #(
   parameter int NUM_LINES = 32,
   parameter int LINE_BITS = 256
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [31:0]          Instr_address_2IC,
   output logic [31:0]          Instr1_fIC,
   output logic                 Hit_fIC,
   output logic                 STALL_2IF,
   input  logic                 Flush_IN,
   output logic [31:0]          Instr_address_2IM,
   output logic                 iBlkRead,
   input  logic [LINE_BITS-1:0] block_read_fIM,
   input  logic                 block_read_fIM_valid,
   output logic [31:0]          Hit_count,
   output logic [31:0]          Miss_count
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = 27 - IDX_W;

   typedef enum logic {IDLE, FILL} state_t;

   state_t                 state, state_nxt;
   logic [NUM_LINES-1:0]   valid_q;
   logic [TAG_W-1:0]       tag_mem  [NUM_LINES];
   logic [LINE_BITS-1:0]   data_mem [NUM_LINES];
   logic [26:0]            fill_addr;

   logic [IDX_W-1:0]       pc_idx, fill_idx;
   logic [TAG_W-1:0]       pc_tag, fill_tag;
   logic [2:0]             pc_off;
   logic [LINE_BITS-1:0]   pc_line;
   logic                   lookup_hit, miss, fill_done;
   logic                   unused_addr_bits;

   assign pc_off   = Instr_address_2IC[4:2];
   assign pc_idx   = Instr_address_2IC[5+IDX_W-1:5];
   assign pc_tag   = Instr_address_2IC[31:5+IDX_W];
   assign fill_idx = fill_addr[IDX_W-1:0];
   assign fill_tag = fill_addr[26:IDX_W];
   assign pc_line  = data_mem[pc_idx];
   assign unused_addr_bits = ^Instr_address_2IC[1:0];

   // Lookups only happen in IDLE; flush and reset both mask the hit.
   assign lookup_hit = (state == IDLE) && valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag)
                       && !Flush_IN && RESET;
   assign miss       = (state == IDLE) && !lookup_hit && !Flush_IN && RESET;
   assign fill_done  = (state == FILL) && block_read_fIM_valid && !Flush_IN;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (Flush_IN) state_nxt = IDLE;
      else begin
         case (state)
            IDLE:    if (miss)                 state_nxt = FILL;
            FILL:    if (block_read_fIM_valid) state_nxt = IDLE;
            default:                           state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      Hit_fIC           = lookup_hit;
      STALL_2IF         = RESET && !lookup_hit;
      Instr1_fIC        = lookup_hit ? pc_line[{pc_off, 5'b0} +: 32] : 32'd0;
      iBlkRead          = RESET && (state == FILL) && !Flush_IN;
      Instr_address_2IM = 32'd0;
      if (RESET)
         Instr_address_2IM = (state == FILL) ? {fill_addr, 5'b0}
                                             : {Instr_address_2IC[31:5], 5'b0};
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)          valid_q <= '0;
      else if (Flush_IN)   valid_q <= '0;
      else if (fill_done)  valid_q[fill_idx] <= 1'b1;
   end

   // Tag and data need no reset: a line is only trusted once its valid bit is set.
   always_ff @(posedge CLK) begin
      if (fill_done) begin
         data_mem[fill_idx] <= block_read_fIM;
         tag_mem[fill_idx]  <= fill_tag;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)    fill_addr <= '0;
      else if (miss) fill_addr <= Instr_address_2IC[31:5];
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         Hit_count  <= '0;
         Miss_count <= '0;
      end else begin
         if (lookup_hit && Hit_count != 32'hFFFF_FFFF)  Hit_count  <= Hit_count + 32'd1;
         if (miss && Miss_count != 32'hFFFF_FFFF)       Miss_count <= Miss_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: table of fetches with a memory responder and an
// expected-word scoreboard, plus flush/reset/redirect sequences during FILL.
module tb_icache_direct;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [31:0]  pc;
   logic [31:0]  instr;
   logic         hit, stall, flush;
   logic [31:0]  addr_im;
   logic         blk_rd;
   logic [255:0] blk;
   logic         blk_valid;
   logic [31:0]  hit_cnt, miss_cnt;

   int n_vec = 0;
   int n_err = 0;
   int model_hits = 0;
   int model_misses = 0;
   logic [31:0] sb_q [$];

   typedef struct {
      logic [31:0] pc;
      int          vdelay;
      int          exp_stalls;
      bit          miss;
   } vec_t;
   vec_t tbl [11];

   always #5 clk = ~clk;

   icache_direct dut (
      .CLK                  (clk),
      .RESET                (rst_n),
      .Instr_address_2IC    (pc),
      .Instr1_fIC           (instr),
      .Hit_fIC              (hit),
      .STALL_2IF            (stall),
      .Flush_IN             (flush),
      .Instr_address_2IM    (addr_im),
      .iBlkRead             (blk_rd),
      .block_read_fIM       (blk),
      .block_read_fIM_valid (blk_valid),
      .Hit_count            (hit_cnt),
      .Miss_count           (miss_cnt)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (w == 32'h0040_0000) return 32'h2008_0005;
      return w ^ 32'h5A5A_0013;
   endfunction

   function automatic logic [255:0] mem_block(input logic [31:0] a);
      logic [255:0] b;
      logic [31:0]  base;
      base = {a[31:5], 5'b0};
      for (int w = 0; w < 8; w++) b[32*w +: 32] = mem_word(base + 32'(4*w));
      return b;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Called just after pc is driven: serve the fill (valid on the vdelay-th
   // iBlkRead cycle) and compare the hit cycle against the scoreboard.
   task automatic wait_hit(input logic [31:0] a, input int vdelay, input int exp_stalls);
      int stalls = 0;
      int fcyc   = 0;
      bit got    = 0;
      sb_q.push_back(mem_word(a));
      for (int c = 0; c < 40 && !got; c++) begin
         #1;
         if (hit) begin
            got = 1;
            chk("instr", instr, sb_q.pop_front());
            chk("stall_on_hit", {31'd0, stall}, 32'd0);
            chk("blkrd_on_hit", {31'd0, blk_rd}, 32'd0);
            chk("stall_cycles", stalls, exp_stalls);
            chk("hit_count", hit_cnt, model_hits);
            chk("miss_count", miss_cnt, model_misses);
            model_hits++;
         end else begin
            stalls++;
            chk("nop_on_miss", instr, 32'd0);
            if (blk_rd) begin
               fcyc++;
               chk("fill_addr", addr_im, {a[31:5], 5'b0});
               if (fcyc == vdelay) begin
                  blk       = mem_block(a);
                  blk_valid = 1'b1;
               end
            end
            @(negedge clk);
            blk_valid = 1'b0;
         end
      end
      if (!got) begin
         n_vec++;
         n_err++;
         $display("FAIL hit_timeout: no hit for pc %h", a);
         void'(sb_q.pop_front());
      end
   endtask

   task automatic fetch(input logic [31:0] a, input int vdelay, input int exp_stalls);
      @(negedge clk);
      pc        = a;
      blk_valid = 1'b0;
      wait_hit(a, vdelay, exp_stalls);
   endtask

   initial begin
      tbl[0] = '{32'h0040_0000, 3, 4, 1'b1};
      for (int i = 1; i < 8; i++) tbl[i] = '{32'h0040_0000 + 32'(4*i), 0, 0, 1'b0};
      tbl[8]  = '{32'h0040_0400, 2, 3, 1'b1};
      tbl[9]  = '{32'h0040_0000, 1, 2, 1'b1};
      tbl[10] = '{32'h0040_0008, 0, 0, 1'b0};

      rst_n = 1'b0; flush = 1'b0; blk_valid = 1'b0; blk = '0; pc = 32'h0040_0000;
      #1;
      chk("rst_blkrd", {31'd0, blk_rd}, 32'd0);
      chk("rst_hit",   {31'd0, hit},    32'd0);
      chk("rst_stall", {31'd0, stall},  32'd0);
      chk("rst_instr", instr,   32'd0);
      chk("rst_addr",  addr_im, 32'd0);
      chk("rst_hcnt",  hit_cnt, 32'd0);
      chk("rst_mcnt",  miss_cnt, 32'd0);
      repeat (2) @(negedge clk);

      // Table: cold miss, same-line hits, conflict eviction and re-miss.
      for (int i = 0; i < 11; i++) begin
         if (tbl[i].miss) model_misses++;
         if (i == 0) begin
            @(negedge clk);
            rst_n = 1'b1;
            pc    = tbl[0].pc;
            wait_hit(tbl[0].pc, tbl[0].vdelay, tbl[0].exp_stalls);
         end else begin
            fetch(tbl[i].pc, tbl[i].vdelay, tbl[i].exp_stalls);
         end
      end
      chk("miss_total", miss_cnt, 32'd3);

      // Flush together with fill valid: data dropped, refill needed.
      @(negedge clk);
      pc = 32'h0040_0020;
      model_misses++;
      #1 chk("fl_stall0", {31'd0, stall}, 32'd1);
      @(negedge clk);
      #1 chk("fl_blkrd1", {31'd0, blk_rd}, 32'd1);
      @(negedge clk);
      flush = 1'b1; blk = mem_block(32'h0040_0020); blk_valid = 1'b1;
      #1;
      chk("fl_blkrd_during", {31'd0, blk_rd}, 32'd0);
      chk("fl_hit_during",   {31'd0, hit},    32'd0);
      chk("fl_stall_during", {31'd0, stall},  32'd1);
      @(negedge clk);
      flush = 1'b0; blk_valid = 1'b0;
      #1;
      chk("fl_blkrd_after", {31'd0, blk_rd}, 32'd0);
      chk("fl_remiss",      {31'd0, hit},    32'd0);
      model_misses++;
      fetch(32'h0040_0020, 2, 2);
      model_misses++;
      fetch(32'h0040_0008, 1, 2);

      // Reset during FILL, then a stray valid in IDLE.
      @(negedge clk);
      pc = 32'h0040_0040;
      model_misses++;
      @(negedge clk);
      #1 chk("rs_blkrd1", {31'd0, blk_rd}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rs_blkrd_drop", {31'd0, blk_rd}, 32'd0);
      chk("rs_hcnt",  hit_cnt,  32'd0);
      chk("rs_mcnt",  miss_cnt, 32'd0);
      chk("rs_addr",  addr_im,  32'd0);
      chk("rs_stall", {31'd0, stall}, 32'd0);
      model_hits = 0;
      model_misses = 0;
      @(negedge clk);
      rst_n = 1'b1; blk = mem_block(32'h0040_0040); blk_valid = 1'b1;
      #1;
      chk("rs_stray_stall", {31'd0, stall}, 32'd1);
      chk("rs_stray_hit",   {31'd0, hit},   32'd0);
      model_misses++;
      fetch(32'h0040_0040, 1, 1);

      // Redirect mid-fill: fill completes for the latched block, then new PC misses.
      @(negedge clk);
      pc = 32'h0040_0000;
      model_misses++;
      @(negedge clk);
      #1 chk("rd_addr1", addr_im, 32'h0040_0000);
      @(negedge clk);
      pc = 32'h0040_0100;
      #1;
      chk("rd_addr_hold", addr_im, 32'h0040_0000);
      chk("rd_blkrd",     {31'd0, blk_rd}, 32'd1);
      @(negedge clk);
      blk = mem_block(32'h0040_0000); blk_valid = 1'b1;
      #1 chk("rd_addr_valid", addr_im, 32'h0040_0000);
      @(negedge clk);
      blk_valid = 1'b0;
      #1;
      chk("rd_new_miss",  {31'd0, stall},  32'd1);
      chk("rd_blkrd_off", {31'd0, blk_rd}, 32'd0);
      chk("rd_new_addr",  addr_im, 32'h0040_0100);
      model_misses++;
      fetch(32'h0040_0100, 2, 2);
      fetch(32'h0040_0000, 0, 0);

      // Flush in IDLE on a resident line masks the hit.
      @(negedge clk);
      flush = 1'b1;
      #1;
      chk("fi_hit",   {31'd0, hit},    32'd0);
      chk("fi_stall", {31'd0, stall},  32'd1);
      chk("fi_instr", instr, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      #1 chk("fi_remiss", {31'd0, hit}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

endmodule
